// File: rtl/acs_pmu.sv
// acs_pmu: add-compare-select / path-metric unit for the 4-state, K=3,
// rate-1/2 Viterbi decoder (generators 7,5). One symbol per clock, with
// registered decisions and normalised path metrics feeding the survivor decoder.
module acs_pmu #(
    parameter int PM_W    = 4,
    parameter int INIT_PM = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      rx,
    output logic            out_valid,
    output logic            d0,
    output logic            d1,
    output logic            d2,
    output logic            d3,
    output logic [PM_W-1:0] pm0,
    output logic [PM_W-1:0] pm1,
    output logic [PM_W-1:0] pm2,
    output logic [PM_W-1:0] pm3,
    output logic [15:0]     sym_cnt
);

    // Candidates carry two extra bits so metric + branch metric never overflows.
    localparam int              CW       = PM_W + 2;
    localparam logic [PM_W-1:0] PM_SAT   = '1;
    localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [PM_W-1:0] pm_q [4];
    logic [PM_W-1:0] pm_d [4];
    logic [3:0]      d_q, d_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     sym_cnt_q, sym_cnt_d;
    logic            state_q, state_d;

    logic [CW-1:0]   cand0 [4];
    logic [CW-1:0]   cand1 [4];
    logic [CW-1:0]   sel   [4];
    logic [CW-1:0]   sel_min;
    logic [PM_W-1:0] norm  [4];
    logic [3:0]      dec;

    // Hamming distance between the encoder output for (predecessor, input) and rx.
    function automatic logic [1:0] branch_metric(input logic [1:0] p,
                                                 input logic       u,
                                                 input logic [1:0] r);
        logic       c0;
        logic       c1;
        logic [1:0] diff;
        c0   = u ^ p[1] ^ p[0];
        c1   = u ^ p[0];
        diff = {c0, c1} ^ r;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // Add-compare-select per next state, then subtract the minimum and saturate.
    always_comb begin
        logic [1:0]    nsb;
        logic [1:0]    p0;
        logic [1:0]    p1;
        logic          u;
        logic [CW-1:0] diff;
        nsb     = '0;
        p0      = '0;
        p1      = '0;
        u       = 1'b0;
        diff    = '0;
        dec     = '0;
        sel_min = '0;
        for (int ns = 0; ns < 4; ns++) begin
            nsb       = 2'(ns);
            u         = nsb[1];
            p0        = {nsb[0], 1'b0};
            p1        = {nsb[0], 1'b1};
            cand0[ns] = CW'(pm_q[p0]) + CW'(branch_metric(p0, u, rx));
            cand1[ns] = CW'(pm_q[p1]) + CW'(branch_metric(p1, u, rx));
            dec[ns]   = (cand1[ns] < cand0[ns]);
            sel[ns]   = dec[ns] ? cand1[ns] : cand0[ns];
        end
        sel_min = sel[0];
        for (int i = 1; i < 4; i++) begin
            if (sel[i] < sel_min) begin
                sel_min = sel[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            diff    = sel[i] - sel_min;
            norm[i] = (diff > CW'(PM_SAT)) ? PM_SAT : diff[PM_W-1:0];
        end
    end

    // Next-state selection: start reinitialises the frame, otherwise a valid symbol updates everything.
    always_comb begin
        pm_d        = pm_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        sym_cnt_d   = sym_cnt_q;
        state_d     = state_q;
        if (start) begin
            pm_d[0]   = '0;
            pm_d[1]   = INIT_VAL;
            pm_d[2]   = INIT_VAL;
            pm_d[3]   = INIT_VAL;
            d_d       = '0;
            sym_cnt_d = '0;
            state_d   = ST_IDLE;
        end else if (in_valid) begin
            pm_d        = norm;
            d_d         = dec;
            out_valid_d = 1'b1;
            sym_cnt_d   = (state_q == ST_IDLE) ? 16'd1 : sym_cnt_q + 16'd1;
            state_d     = ST_RUN;
        end
    end

    // State registers with synchronous active-low reset to the frame-start values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pm_q[0]     <= '0;
            pm_q[1]     <= INIT_VAL;
            pm_q[2]     <= INIT_VAL;
            pm_q[3]     <= INIT_VAL;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            sym_cnt_q   <= '0;
            state_q     <= ST_IDLE;
        end else begin
            pm_q        <= pm_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            sym_cnt_q   <= sym_cnt_d;
            state_q     <= state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign d0        = d_q[0];
    assign d1        = d_q[1];
    assign d2        = d_q[2];
    assign d3        = d_q[3];
    assign pm0       = pm_q[0];
    assign pm1       = pm_q[1];
    assign pm2       = pm_q[2];
    assign pm3       = pm_q[3];
    assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_acs_pmu.sv
// tb_acs_pmu: directed and model-checked bench for the Viterbi ACS/path-metric unit.
module tb_acs_pmu;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [1:0]  rx;
    logic        out_valid;
    logic        d0, d1, d2, d3;
    logic [3:0]  pm0, pm1, pm2, pm3;
    logic [15:0] sym_cnt;

    int n_cmp;
    int n_err;
    int mpm [4];
    logic [3:0] mdec;

    logic [15:0] pm_all;
    logic [3:0]  d_all;
    assign pm_all = {pm3, pm2, pm1, pm0};
    assign d_all  = {d3, d2, d1, d0};

    acs_pmu #(.PM_W(4), .INIT_PM(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .rx        (rx),
        .out_valid (out_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .pm0       (pm0),
        .pm1       (pm1),
        .pm2       (pm2),
        .pm3       (pm3),
        .sym_cnt   (sym_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        rx       = 2'b00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Forward-trellis reference: walk every (state, input) branch, keep the strictly better one.
    task automatic model_reset;
        mpm[0] = 0;
        mpm[1] = 8;
        mpm[2] = 8;
        mpm[3] = 8;
        mdec   = 4'b0000;
    endtask

    task automatic model_step(input logic [1:0] r);
        int best [4];
        int bdec [4];
        int s1, s0, c0, c1, bm, nxt, cand, mn;
        for (int i = 0; i < 4; i++) begin
            best[i] = 1000;
            bdec[i] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                s1   = (p >> 1) & 1;
                s0   = p & 1;
                c0   = u ^ s1 ^ s0;
                c1   = u ^ s0;
                bm   = ((c0 != int'(r[1])) ? 1 : 0) + ((c1 != int'(r[0])) ? 1 : 0);
                nxt  = 2 * u + s1;
                cand = mpm[p] + bm;
                if (cand < best[nxt]) begin
                    best[nxt] = cand;
                    bdec[nxt] = s0;
                end
            end
        end
        mn = best[0];
        for (int i = 1; i < 4; i++) if (best[i] < mn) mn = best[i];
        for (int i = 0; i < 4; i++) begin
            mpm[i]  = (best[i] - mn > 15) ? 15 : best[i] - mn;
            mdec[i] = (bdec[i] != 0);
        end
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        n_cmp++; if (pm_all !== 16'h8880) begin n_err++; $display("[TB] FAIL reset_pm: got %h expected %h", pm_all, 16'h8880); end
        n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_d: got %b expected %b", d_all, 4'b0000); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ov: got %b expected 0", out_valid); end
        n_cmp++; if (sym_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d expected 0", sym_cnt); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        in_valid = 1'b1;
        rx       = 2'b00;
        tick();
        n_cmp++; if (pm_all !== 16'h9290) begin n_err++; $display("[TB] FAIL b2b_pm1: got %h expected %h", pm_all, 16'h9290); end
        n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL b2b_d1: got %b expected %b", d_all, 4'b0000); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ov1: got %b expected 1", out_valid); end
        tick();
        n_cmp++; if (pm_all !== 16'h3230) begin n_err++; $display("[TB] FAIL b2b_pm2: got %h expected %h", pm_all, 16'h3230); end
        n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL b2b_d2: got %b expected %b", d_all, 4'b0000); end
        n_cmp++; if (sym_cnt !== 16'd2) begin n_err++; $display("[TB] FAIL b2b_cnt: got %0d expected 2", sym_cnt); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_11;
        do_reset();
        in_valid = 1'b1;
        rx       = 2'b11;
        tick();
        n_cmp++; if (pm_all !== 16'h9092) begin n_err++; $display("[TB] FAIL s11_pm: got %h expected %h", pm_all, 16'h9092); end
        n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL s11_d: got %b expected %b", d_all, 4'b0000); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL s11_ov: got %b expected 1", out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL s11_ov_pulse: got %b expected 0", out_valid); end
        n_cmp++; if (pm_all !== 16'h9092) begin n_err++; $display("[TB] FAIL s11_pm_hold: got %h expected %h", pm_all, 16'h9092); end
        n_cmp++; if (sym_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL s11_cnt: got %0d expected 1", sym_cnt); end
    endtask

    task automatic test_gaps;
        logic        vpat   [4];
        logic [15:0] exp_pm [4];
        logic [15:0] exp_cnt[4];
        vpat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_pm = '{16'h9290, 16'h9290, 16'h9290, 16'h3230};
        exp_cnt= '{16'd1, 16'd1, 16'd1, 16'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = vpat[i];
            rx       = vpat[i] ? 2'b00 : 2'b11;
            tick();
            n_cmp++; if (out_valid !== vpat[i]) begin n_err++; $display("[TB] FAIL gap_ov[%0d]: got %b expected %b", i, out_valid, vpat[i]); end
            n_cmp++; if (pm_all !== exp_pm[i]) begin n_err++; $display("[TB] FAIL gap_pm[%0d]: got %h expected %h", i, pm_all, exp_pm[i]); end
            n_cmp++; if (sym_cnt !== exp_cnt[i]) begin n_err++; $display("[TB] FAIL gap_cnt[%0d]: got %0d expected %0d", i, sym_cnt, exp_cnt[i]); end
            n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL gap_d[%0d]: got %b expected 0000", i, d_all); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_midstream;
        in_valid = 1'b1;
        rx       = 2'b11;
        tick();
        n_cmp++; if (pm_all !== 16'h3032) begin n_err++; $display("[TB] FAIL mid_pm: got %h expected %h", pm_all, 16'h3032); end
        n_cmp++; if (sym_cnt !== 16'd3) begin n_err++; $display("[TB] FAIL mid_cnt: got %0d expected 3", sym_cnt); end
        start = 1'b1;
        rx    = 2'b00;
        tick();
        start = 1'b0;
        n_cmp++; if (pm_all !== 16'h8880) begin n_err++; $display("[TB] FAIL start_pm: got %h expected %h", pm_all, 16'h8880); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL start_ov: got %b expected 0", out_valid); end
        n_cmp++; if (sym_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL start_cnt: got %0d expected 0", sym_cnt); end
        n_cmp++; if (d_all !== 4'b0000) begin n_err++; $display("[TB] FAIL start_d: got %b expected 0000", d_all); end
        rx = 2'b11;
        tick();
        n_cmp++; if (pm_all !== 16'h9092) begin n_err++; $display("[TB] FAIL restart_pm: got %h expected %h", pm_all, 16'h9092); end
        n_cmp++; if (sym_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL restart_cnt: got %0d expected 1", sym_cnt); end
        reset = 1'b0;
        start = 1'b1;
        tick();
        n_cmp++; if (pm_all !== 16'h8880) begin n_err++; $display("[TB] FAIL rst_start_pm: got %h expected %h", pm_all, 16'h8880); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_start_ov: got %b expected 0", out_valid); end
        n_cmp++; if (sym_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL rst_start_cnt: got %0d expected 0", sym_cnt); end
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random_stream;
        logic [1:0]  enc_s;
        logic        u;
        logic [1:0]  r;
        logic [15:0] exp_pm;
        logic [3:0]  min_pm;
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        model_reset();
        enc_s = 2'b00;
        for (int i = 0; i < 200; i++) begin
            u     = 1'($urandom_range(0, 1));
            r     = {u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0]};
            enc_s = {u, enc_s[1]};
            if (i % 10 == 7) r = r ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            rx       = r;
            in_valid = 1'b1;
            tick();
            model_step(r);
            exp_pm = {4'(mpm[3]), 4'(mpm[2]), 4'(mpm[1]), 4'(mpm[0])};
            min_pm = pm0;
            if (pm1 < min_pm) min_pm = pm1;
            if (pm2 < min_pm) min_pm = pm2;
            if (pm3 < min_pm) min_pm = pm3;
            n_cmp++; if (d_all !== mdec) begin n_err++; $display("[TB] FAIL rand_d sym %0d: got %b expected %b", i, d_all, mdec); end
            n_cmp++; if (pm_all !== exp_pm) begin n_err++; $display("[TB] FAIL rand_pm sym %0d: got %h expected %h", i, pm_all, exp_pm); end
            n_cmp++; if (min_pm !== 4'd0) begin n_err++; $display("[TB] FAIL rand_minpm sym %0d: got %0d expected 0", i, min_pm); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rand_ov sym %0d: got %b expected 1", i, out_valid); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (sym_cnt !== 16'd200) begin n_err++; $display("[TB] FAIL rand_cnt: got %0d expected 200", sym_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rand_ov_end: got %b expected 0", out_valid); end
    endtask

    // Test sequence.
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        rx       = 2'b00;
        $display("[TB] starting acs_pmu bench");
        test_reset();
        test_back_to_back();
        test_single_11();
        test_gaps();
        test_start_midstream();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
